// File: rtl/lfsr_seq_ctrl.sv
// LFSR word sequencer: steps a Fibonacci-style LFSR S times per output word and streams COUNT words.
// Optional build macro LFSR_ZERO_SEED_CHK_EN rejects zero-seed jobs with a ZERO_ERR_O pulse.
module lfsr_seq_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             CFG_VALID_I,
  output logic             CFG_READY_O,
  input  logic [W-1:0]     POLY_I,
  input  logic [W-1:0]     SEED_I,
  input  logic [W-1:0]     SHIFT_I,
  input  logic [CNT_W-1:0] COUNT_I,
  input  logic             ABORT_I,
  output logic [W-1:0]     DATA_O,
  output logic             DATA_VALID_O,
  input  logic             DATA_READY_I,
  output logic             BUSY_O,
  output logic             DONE_O,
  output logic             ZERO_ERR_O
);

  typedef enum logic [1:0] {IDLE, STEP, OUT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_lfsr;
  logic [W-1:0]     r_poly;
  logic [W-1:0]     r_shift;
  logic [W-1:0]     r_step_cnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_done;

  logic             w_accept;
  logic             w_zero_reject;
  logic             w_out_hs;
  logic             w_last_word;
  logic [W-1:0]     w_shift_eff;
  logic [W-1:0]     w_lfsr_step;

  assign w_accept    = CFG_VALID_I && (r_state == IDLE);
  assign w_shift_eff = (SHIFT_I == '0) ? {{(W-1){1'b0}}, 1'b1} : SHIFT_I;
  assign w_lfsr_step = {r_lfsr[W-2:0], ^(r_lfsr & r_poly)};
  assign w_out_hs    = (r_state == OUT) && DATA_READY_I;
  assign w_last_word = (r_word_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

`ifdef LFSR_ZERO_SEED_CHK_EN
  logic r_zero_err;

  assign w_zero_reject = (SEED_I == '0) && (COUNT_I != '0);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_zero_err <= 1'b0;
    end else begin
      r_zero_err <= w_accept && w_zero_reject;
    end
  end

  assign ZERO_ERR_O = r_zero_err;
`else
  assign w_zero_reject = 1'b0;
  assign ZERO_ERR_O    = 1'b0;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    CFG_READY_O  = 1'b0;
    BUSY_O       = 1'b0;
    DATA_VALID_O = 1'b0;
    DATA_O       = '0;
    case (r_state)
      IDLE: begin
        CFG_READY_O = 1'b1;
        if (w_accept && (COUNT_I != '0) && !w_zero_reject) begin
          w_state_next = STEP;
        end
      end
      STEP: begin
        BUSY_O = 1'b1;
        if (ABORT_I) begin
          w_state_next = IDLE;
        end else if (r_step_cnt == {{(W-1){1'b0}}, 1'b1}) begin
          w_state_next = OUT;
        end
      end
      OUT: begin
        BUSY_O       = 1'b1;
        DATA_VALID_O = 1'b1;
        DATA_O       = r_lfsr;
        // Abort wins the next state even when the word handshakes this cycle.
        if (ABORT_I) begin
          w_state_next = IDLE;
        end else if (DATA_READY_I) begin
          w_state_next = w_last_word ? IDLE : STEP;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_lfsr     <= '0;
      r_poly     <= '0;
      r_shift    <= '0;
      r_step_cnt <= '0;
      r_word_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_poly     <= POLY_I;
            r_lfsr     <= SEED_I;
            r_shift    <= w_shift_eff;
            r_step_cnt <= w_shift_eff;
            r_word_cnt <= COUNT_I;
            r_done     <= (COUNT_I == '0);
          end
        end
        STEP: begin
          r_lfsr     <= w_lfsr_step;
          r_step_cnt <= r_step_cnt - 1'b1;
        end
        OUT: begin
          if (w_out_hs) begin
            r_word_cnt <= r_word_cnt - 1'b1;
            r_step_cnt <= r_shift;
            r_done     <= w_last_word && !ABORT_I;
          end
        end
        default: ;
      endcase
    end
  end

  assign DONE_O = r_done;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: table of jobs with hand-computed words plus
// hand sequences for backpressure, abort and reset corners.
module tb_lfsr_seq_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        CFG_VALID_I;
  logic        CFG_READY_O;
  logic [7:0]  POLY_I;
  logic [7:0]  SEED_I;
  logic [7:0]  SHIFT_I;
  logic [15:0] COUNT_I;
  logic        ABORT_I;
  logic [7:0]  DATA_O;
  logic        DATA_VALID_O;
  logic        DATA_READY_I;
  logic        BUSY_O;
  logic        DONE_O;
  logic        ZERO_ERR_O;

  int n_cmp = 0;
  int n_err = 0;

  lfsr_seq_ctrl #(.W(8), .CNT_W(16)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CFG_VALID_I(CFG_VALID_I), .CFG_READY_O(CFG_READY_O),
    .POLY_I(POLY_I), .SEED_I(SEED_I), .SHIFT_I(SHIFT_I), .COUNT_I(COUNT_I),
    .ABORT_I(ABORT_I), .DATA_O(DATA_O), .DATA_VALID_O(DATA_VALID_O),
    .DATA_READY_I(DATA_READY_I), .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ZERO_ERR_O(ZERO_ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [7:0]       poly;
    logic [7:0]       seed;
    logic [7:0]       shift;
    logic [15:0]      count;
    int               n_words;
    logic [3:0][7:0]  w;
    int               exp_done;
    int               exp_zero;
  } job_t;

  job_t jobs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Called one step after an edge; returns one step after the accepting edge.
  task automatic accept(input logic [7:0] poly, input logic [7:0] seed,
                        input logic [7:0] shift, input logic [15:0] count);
    POLY_I = poly; SEED_I = seed; SHIFT_I = shift; COUNT_I = count;
    CFG_VALID_I = 1'b1;
    tick();
    CFG_VALID_I = 1'b0;
  endtask

  initial begin
    int s_eff, got, dones, zeros, done_c, vcnt, dcnt;

    jobs[0] = '{8'hB8, 8'h01, 8'd1, 16'd3, 3, {8'h00, 8'h08, 8'h04, 8'h02}, 1, 0};
    jobs[1] = '{8'hB8, 8'h01, 8'd4, 16'd2, 2, {8'h00, 8'h00, 8'h1C, 8'h11}, 1, 0};
    jobs[2] = '{8'hB8, 8'h01, 8'd0, 16'd2, 2, {8'h00, 8'h00, 8'h04, 8'h02}, 1, 0};
    jobs[3] = '{8'hB8, 8'h01, 8'd1, 16'd0, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 0};
    jobs[4] = '{8'hB8, 8'h11, 8'd1, 16'd2, 2, {8'h00, 8'h00, 8'h47, 8'h23}, 1, 0};
`ifdef LFSR_ZERO_SEED_CHK_EN
    jobs[5] = '{8'hB8, 8'h00, 8'd1, 16'd1, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1};
`else
    jobs[5] = '{8'hB8, 8'h00, 8'd1, 16'd1, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 0};
`endif

    RST_I = 1'b1; CFG_VALID_I = 1'b0; POLY_I = '0; SEED_I = '0; SHIFT_I = '0;
    COUNT_I = '0; ABORT_I = 1'b0; DATA_READY_I = 1'b1;
    tick(); tick();
    chk("rst_cfg_ready", CFG_READY_O, 1);
    chk("rst_valid", DATA_VALID_O, 0);
    chk("rst_data", DATA_O, 0);
    chk("rst_busy", BUSY_O, 0);
    chk("rst_done", DONE_O, 0);
    chk("rst_zero_err", ZERO_ERR_O, 0);
    RST_I = 1'b0;
    tick();

    for (int j = 0; j < 6; j++) begin
      s_eff = (jobs[j].shift == 0) ? 1 : int'(jobs[j].shift);
      accept(jobs[j].poly, jobs[j].seed, jobs[j].shift, jobs[j].count);
      got = 0; dones = 0; zeros = 0; done_c = -1;
      for (int c = 0; c < 60; c++) begin
        if (DATA_VALID_O) begin
          if (got < 4) begin
            chk($sformatf("job%0d_word%0d", j, got), DATA_O, jobs[j].w[got]);
            chk($sformatf("job%0d_time%0d", j, got), c, s_eff + got * (s_eff + 1));
          end
          got++;
        end
        if (DONE_O) begin dones++; done_c = c; end
        if (ZERO_ERR_O) zeros++;
        tick();
      end
      chk($sformatf("job%0d_nwords", j), got, jobs[j].n_words);
      chk($sformatf("job%0d_ndone", j), dones, jobs[j].exp_done);
      chk($sformatf("job%0d_nzero", j), zeros, jobs[j].exp_zero);
      if (jobs[j].exp_done == 1)
        chk($sformatf("job%0d_done_time", j), done_c,
            (jobs[j].n_words == 0) ? 0 : s_eff + (jobs[j].n_words - 1) * (s_eff + 1) + 1);
      chk($sformatf("job%0d_idle_ready", j), CFG_READY_O, 1);
      $display("job %0d: seed=%02h shift=%0d count=%0d words=%0d done=%0d zero_err=%0d",
               j, jobs[j].seed, jobs[j].shift, jobs[j].count, got, dones, zeros);
    end

    // Backpressure: first word must hold for 5 stalled cycles.
    DATA_READY_I = 1'b0;
    accept(8'hB8, 8'h01, 8'd1, 16'd2);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", DATA_VALID_O, 1);
      chk("bp_hold_data", DATA_O, 8'h02);
      if (c < 4) tick();
    end
    DATA_READY_I = 1'b1;
    tick();
    chk("bp_gap_valid", DATA_VALID_O, 0);
    tick();
    chk("bp_word2_valid", DATA_VALID_O, 1);
    chk("bp_word2_data", DATA_O, 8'h04);
    tick();
    chk("bp_done", DONE_O, 1);
    $display("seq backpressure: done");

    // Abort while stepping toward word 2.
    accept(8'hB8, 8'h01, 8'd4, 16'd3);
    repeat (4) tick();
    chk("ab_word1_data", DATA_O, 8'h11);
    repeat (2) tick();
    chk("ab_step_busy", BUSY_O, 1);
    chk("ab_step_valid", DATA_VALID_O, 0);
    ABORT_I = 1'b1;
    tick();
    ABORT_I = 1'b0;
    chk("ab_cfg_ready", CFG_READY_O, 1);
    chk("ab_busy", BUSY_O, 0);
    chk("ab_valid", DATA_VALID_O, 0);
    chk("ab_done", DONE_O, 0);
    vcnt = 0; dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (DATA_VALID_O) vcnt++;
      if (DONE_O) dcnt++;
      tick();
    end
    chk("ab_after_valid", vcnt, 0);
    chk("ab_after_done", dcnt, 0);
    $display("seq abort-in-step: done");

    // Abort in IDLE is ignored at the accept edge.
    ABORT_I = 1'b1;
    accept(8'hB8, 8'h01, 8'd1, 16'd1);
    ABORT_I = 1'b0;
    chk("idle_abort_busy", BUSY_O, 1);
    tick();
    chk("idle_abort_data", DATA_O, 8'h02);
    tick();
    chk("idle_abort_done", DONE_O, 1);
    $display("seq abort-in-idle: done");

    // Reset mid-job discards it silently.
    accept(8'hB8, 8'h01, 8'd4, 16'd2);
    repeat (2) tick();
    RST_I = 1'b1;
    #1;
    chk("mrst_busy", BUSY_O, 0);
    chk("mrst_cfg_ready", CFG_READY_O, 1);
    chk("mrst_valid", DATA_VALID_O, 0);
    tick();
    RST_I = 1'b0;
    vcnt = 0; dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (DATA_VALID_O) vcnt++;
      if (DONE_O) dcnt++;
      tick();
    end
    chk("mrst_after_valid", vcnt, 0);
    chk("mrst_after_done", dcnt, 0);
    $display("seq mid-job reset: done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving LFSR state, polynomial and shift-count width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving word-count width.
REQ-003 The block SHALL have port CLK_I, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_I, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port CFG_VALID_I, input, 1, job request valid.
REQ-006 The block SHALL have port CFG_READY_O, output, 1, job can be accepted.
REQ-007 The block SHALL have ports POLY_I, SEED_I and SHIFT_I, each input, W, giving tap mask, start state, and LFSR steps per output word.
REQ-008 The block SHALL have port COUNT_I, input, CNT_W, the number of words to emit.
REQ-009 The block SHALL have port ABORT_I, input, 1, a synchronous job cancel.
REQ-010 The block SHALL have ports DATA_O (output, W, word) and DATA_VALID_O (output, 1, word valid).
REQ-011 The block SHALL have port DATA_READY_I, input, 1, consumer accepts the word.
REQ-012 The block SHALL have ports BUSY_O (output, 1, job active) and DONE_O (output, 1, one-cycle pulse on job completion).
REQ-013 The block SHALL have port ZERO_ERR_O, output, 1, one-cycle pulse when a zero-seed job is rejected.

Function
REQ-014 The block SHALL perform one LFSR step as state <= {state[W-2:0], ^(state & poly)}, i.e. shift left with XOR-reduced feedback into bit 0.
REQ-015 The FSM SHALL have exactly the states IDLE, STEP and OUT.
REQ-016 CFG_READY_O SHALL be 1 only in IDLE.
REQ-017 A job SHALL be accepted on the edge where CFG_VALID_I and CFG_READY_O are both 1; POLY, SEED, SHIFT and COUNT SHALL be registered on that edge.
REQ-018 A job with COUNT_I==0 SHALL complete immediately: DONE_O pulses on the next cycle, no data is produced, and the FSM stays in IDLE.
REQ-019 A shift count SHALL be taken as SHIFT_I when nonzero; SHIFT_I==0 SHALL be treated as 1.
REQ-020 On acceptance of a job with count >0, the FSM SHALL go to STEP; STEP SHALL perform one LFSR step per cycle for exactly the shift count S, then go to OUT.
REQ-021 In OUT, DATA_VALID_O SHALL be 1 and DATA_O SHALL equal the current LFSR state; both SHALL be held stable until DATA_READY_I is 1.
REQ-022 On an OUT handshake for the last word, DONE_O SHALL pulse in the following cycle and the FSM SHALL go to IDLE; otherwise the FSM SHALL go to STEP with the LFSR state kept (no reseed).
REQ-023 Latency: with accept at edge k, DATA_VALID_O SHALL first assert after edge k+S; with DATA_READY_I held at 1, words SHALL be emitted every S+1 cycles.
REQ-024 ABORT_I==1 in STEP or OUT SHALL force IDLE at the next edge, drop DATA_VALID_O, and suppress DONE_O; ABORT_I in IDLE SHALL be ignored.
REQ-025 If ABORT_I and an OUT handshake occur in the same cycle, the word SHALL count as transferred and abort SHALL take priority for the next state.
REQ-026 BUSY_O SHALL be 1 in STEP and OUT.
REQ-027 The word counter SHALL be CNT_W bits, so COUNT_I = 2^CNT_W-1 runs to completion without wrap.

Reset
REQ-028 While RST_I is 1, the FSM SHALL be in IDLE and all registers SHALL be 0.
REQ-029 While RST_I is 1, every output SHALL be 0 except CFG_READY_O, which SHALL be 1.
REQ-030 Reset mid-job SHALL discard the job without a DONE_O pulse.

Configuration
REQ-031 When LFSR_ZERO_SEED_CHK_EN is defined, a job with SEED_I==0 and COUNT_I>0 SHALL be rejected: ZERO_ERR_O pulses the next cycle, the FSM stays in IDLE, and DONE_O does not pulse.
REQ-032 When LFSR_ZERO_SEED_CHK_EN is undefined, ZERO_ERR_O SHALL be tied to 0 and a zero seed SHALL run normally, emitting all-zero words.

Verification
REQ-033 The bench SHALL check: POLY=8'hB8, SEED=8'h01, SHIFT=1, COUNT=3, ready=1 -> DATA_O 8'h02, 8'h04, 8'h08 every 2 cycles, then one DONE_O pulse.
REQ-034 The bench SHALL check: same POLY/SEED, SHIFT=4, COUNT=2 -> words 8'h11 then 8'h1C, first valid 4 cycles after accept.
REQ-035 The bench SHALL check: SHIFT=1, COUNT=2, DATA_READY_I low 5 cycles -> DATA_O held at 8'h02 with valid high throughout, then 8'h04.
REQ-036 The bench SHALL check: ABORT_I pulse during STEP of word 2 -> FSM in IDLE next cycle, no valid, no DONE_O, CFG_READY_O=1.
REQ-037 The bench SHALL check: COUNT=0 -> DONE_O pulse only; SHIFT=0 -> behaves as SHIFT=1.
REQ-038 The bench SHALL check: SEED=0, COUNT=1 with LFSR_ZERO_SEED_CHK_EN defined -> ZERO_ERR_O pulse and no data; undefined -> one word 8'h00 and DONE_O.
